// File: rtl/bit_sparsity_pkg.sv
// Shared definitions for the bit-sparsity datapath: default widths and the
// accumulator handshake states.
package bit_sparsity_pkg;

  localparam int PLACE_WIDTH  = 3;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ACC_WIDTH    = 20;
  localparam int CNT_WIDTH    = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

// File: rtl/shift_add_unit.sv
// Combinational term adder: sign-extends the weight, shifts it to the activation
// bit position, adds it to the running sum and flags signed overflow.
module shift_add_unit #(
  parameter int ACC_WIDTH    = bit_sparsity_pkg::ACC_WIDTH,
  parameter int WEIGHT_WIDTH = bit_sparsity_pkg::WEIGHT_WIDTH,
  parameter int PLACE_WIDTH  = bit_sparsity_pkg::PLACE_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]    acc,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  input  logic [PLACE_WIDTH-1:0]  place,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    overflow
);

  logic [ACC_WIDTH-1:0] addend;

  always_comb begin
    addend   = {{(ACC_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight} << place;
    sum      = acc + addend;
    // Overflow only when both operands share a sign and the result flips it.
    overflow = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  end

endmodule

// File: rtl/bit_plane_accumulator.sv
// Accumulates Weight << BitPlace per accepted beat and presents the group sum,
// term count and overflow flag through a valid/ready result port.
module bit_plane_accumulator #(
  parameter int ACC_WIDTH    = bit_sparsity_pkg::ACC_WIDTH,
  parameter int WEIGHT_WIDTH = bit_sparsity_pkg::WEIGHT_WIDTH,
  parameter int PLACE_WIDTH  = bit_sparsity_pkg::PLACE_WIDTH,
  parameter int CNT_WIDTH    = bit_sparsity_pkg::CNT_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [PLACE_WIDTH-1:0]  BitPlace,
  input  logic [WEIGHT_WIDTH-1:0] Weight,
  input  logic                    InEmpty,
  input  logic                    GroupLast,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [ACC_WIDTH-1:0]    OutSum,
  output logic [CNT_WIDTH-1:0]    OutTerms,
  output logic                    OutOverflow
);

  import bit_sparsity_pkg::*;

  acc_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_nxt, sa_sum;
  logic [CNT_WIDTH-1:0] terms_q, terms_nxt;
  logic                 ovf_q, ovf_nxt, sa_ovf;
  logic                 accept;

  shift_add_unit #(
    .ACC_WIDTH   (ACC_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .PLACE_WIDTH (PLACE_WIDTH)
  ) u_shift_add (
    .acc     (acc_q),
    .weight  (Weight),
    .place   (BitPlace),
    .sum     (sa_sum),
    .overflow(sa_ovf)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ACC: begin
        if (InValid) begin
          accept = 1'b1;
          if (GroupLast) state_d = HOLD;
        end
      end
      HOLD: begin
        if (OutReady) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Post-update values; also what gets published when the beat closes a group.
  always_comb begin
    acc_nxt   = acc_q;
    terms_nxt = terms_q;
    ovf_nxt   = ovf_q;
    if (!InEmpty) begin
      acc_nxt   = sa_sum;
      terms_nxt = (terms_q == '1) ? terms_q : terms_q + 1'b1;
      ovf_nxt   = ovf_q | sa_ovf;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACC;
      acc_q       <= '0;
      terms_q     <= '0;
      ovf_q       <= 1'b0;
      OutSum      <= '0;
      OutTerms    <= '0;
      OutOverflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (GroupLast) begin
          OutSum      <= acc_nxt;
          OutTerms    <= terms_nxt;
          OutOverflow <= ovf_nxt;
          acc_q       <= '0;
          terms_q     <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q   <= acc_nxt;
          terms_q <= terms_nxt;
          ovf_q   <= ovf_nxt;
        end
      end
    end
  end

  assign InReady  = (state_q == ACC);
  assign OutValid = (state_q == HOLD);

endmodule

// File: tb/tb_bit_plane_accumulator.sv
// Directed and randomized checks of bit_plane_accumulator against an
// integer-arithmetic reference of the group dot product.
module tb_bit_plane_accumulator;

  localparam int AW = 20;
  localparam int WW = 8;
  localparam int PW = 3;
  localparam int CW = 8;
  localparam int ACC_MAX = (1 << (AW-1)) - 1;
  localparam int ACC_MIN = -(1 << (AW-1));

  logic          CLK = 1'b0;
  logic          RST;
  logic          InValid;
  logic          InReady;
  logic [PW-1:0] BitPlace;
  logic [WW-1:0] Weight;
  logic          InEmpty;
  logic          GroupLast;
  logic          OutValid;
  logic          OutReady;
  logic [AW-1:0] OutSum;
  logic [CW-1:0] OutTerms;
  logic          OutOverflow;

  int checks = 0;
  int errors = 0;

  // Reference state: true integer sum kept in range, term count, sticky overflow
  int            m_acc;
  int            m_terms;
  bit            m_ovf;
  logic [AW-1:0] e_sum;
  int            e_terms;
  bit            e_ovf;

  bit_plane_accumulator #(
    .ACC_WIDTH   (AW),
    .WEIGHT_WIDTH(WW),
    .PLACE_WIDTH (PW),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .InValid    (InValid),
    .InReady    (InReady),
    .BitPlace   (BitPlace),
    .Weight     (Weight),
    .InEmpty    (InEmpty),
    .GroupLast  (GroupLast),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutSum     (OutSum),
    .OutTerms   (OutTerms),
    .OutOverflow(OutOverflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_terms = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_beat(input int w, input int p, input bit empty, input bit last);
    logic signed [WW-1:0] ws;
    int r;
    ws = w[WW-1:0];
    if (!empty) begin
      r = m_acc + int'(ws) * (1 << p);
      if (r > ACC_MAX) begin r = r - (1 << AW); m_ovf = 1'b1; end
      if (r < ACC_MIN) begin r = r + (1 << AW); m_ovf = 1'b1; end
      m_acc   = r;
      m_terms = (m_terms >= (1 << CW) - 1) ? (1 << CW) - 1 : m_terms + 1;
    end
    if (last) begin
      e_sum   = m_acc[AW-1:0];
      e_terms = m_terms;
      e_ovf   = m_ovf;
      model_reset();
    end
  endtask

  // Present a beat, wait (bounded) until the DUT is ready, let one edge take it.
  task automatic beat(input int w, input int p, input bit empty, input bit last);
    int waited;
    waited    = 0;
    InValid   = 1'b1;
    Weight    = w[WW-1:0];
    BitPlace  = p[PW-1:0];
    InEmpty   = empty;
    GroupLast = last;
    while (!InReady && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (!InReady) chk("in_ready_timeout", InReady, 1);
    @(posedge CLK); #1;
    InValid = 1'b0;
    model_beat(w, p, empty, last);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, OutValid, 1);
    chk({tag, "_sum"}, OutSum, e_sum);
    chk({tag, "_terms"}, OutTerms, e_terms);
    chk({tag, "_ovf"}, OutOverflow, e_ovf);
  endtask

  task automatic handshake(input string tag);
    OutReady = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b0;
    chk({tag, "_valid_drop"}, OutValid, 0);
    chk({tag, "_ready_back"}, InReady, 1);
    chk({tag, "_sum_kept"}, OutSum, e_sum);
  endtask

  initial begin
    RST = 1'b1; InValid = 1'b0; BitPlace = '0; Weight = '0;
    InEmpty = 1'b0; GroupLast = 1'b0; OutReady = 1'b0;
    model_reset();
    e_sum = '0; e_terms = 0; e_ovf = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", OutValid, 0);
    chk("rst_sum", OutSum, 0);
    chk("rst_terms", OutTerms, 0);
    chk("rst_ovf", OutOverflow, 0);
    #2 RST = 1'b0;
    #1 chk("rst_in_ready", InReady, 1);
    @(posedge CLK); #1;

    // Basic group
    beat(5, 0, 0, 0);
    beat(5, 1, 0, 1);
    check_result("basic");
    chk("basic_sum_const", OutSum, 15);
    chk("basic_terms_const", OutTerms, 2);
    handshake("basic");

    // Negative weight, activation 0xF7
    beat(-3, 0, 0, 0); beat(-3, 1, 0, 0); beat(-3, 2, 0, 0);
    beat(-3, 4, 0, 0); beat(-3, 5, 0, 0); beat(-3, 6, 0, 0);
    beat(-3, 7, 0, 1);
    check_result("neg");
    chk("neg_sum_const", OutSum, 32'h000F_FD1B);
    chk("neg_terms_const", OutTerms, 7);
    handshake("neg");

    // Empty single-beat group then a fresh one-term group
    beat(0, 0, 1, 1);
    check_result("empty");
    chk("empty_sum_const", OutSum, 0);
    handshake("empty");
    beat(2, 3, 0, 1);
    chk("after_empty_sum", OutSum, 16);
    chk("after_empty_terms", OutTerms, 1);
    handshake("after_empty");

    // Backpressure with a pending beat
    beat(7, 2, 0, 1);
    chk("bp_sum_const", OutSum, 28);
    InValid = 1'b1; Weight = 8'd3; BitPlace = 3'd1; InEmpty = 1'b0; GroupLast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("bp_valid_hold", OutValid, 1);
      chk("bp_sum_hold", OutSum, 28);
      chk("bp_in_ready_low", InReady, 0);
    end
    OutReady = 1'b1;
    @(posedge CLK); #1;
    OutReady = 1'b0;
    chk("bp_valid_drop", OutValid, 0);
    chk("bp_ready_back", InReady, 1);
    @(posedge CLK); #1;
    InValid = 1'b0;
    model_beat(3, 1, 0, 0);
    beat(1, 0, 0, 1);
    check_result("bp_pending");
    chk("bp_pending_sum_const", OutSum, 7);
    chk("bp_pending_terms_const", OutTerms, 2);
    handshake("bp_pending");

    // Overflow: 33 x (127 << 7)
    for (int i = 0; i < 33; i++) beat(127, 7, 0, (i == 32));
    check_result("ovf");
    chk("ovf_flag_const", OutOverflow, 1);
    chk("ovf_sum_const", OutSum, 32'h0008_2F80);
    chk("ovf_terms_const", OutTerms, 33);
    handshake("ovf");

    // Term counter saturation
    for (int i = 0; i < 300; i++) beat(1, 0, 0, (i == 299));
    check_result("sat");
    chk("sat_terms_const", OutTerms, 255);
    handshake("sat");

    // Randomized groups with idle gaps and delayed result consumption
    for (int g = 0; g < 40; g++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 1)) begin @(posedge CLK); #1; end
        beat($urandom_range(0, 255), $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0), (b == len - 1));
      end
      check_result("rand");
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
        chk("rand_hold_sum", OutSum, e_sum);
      end
      handshake("rand");
    end

    // Reset mid-group: Out* currently holds the last random result
    beat(9, 1, 0, 0); beat(9, 2, 0, 0); beat(9, 3, 0, 0);
    #2 RST = 1'b1;
    #1;
    chk("midrst_valid", OutValid, 0);
    chk("midrst_sum", OutSum, 0);
    chk("midrst_terms", OutTerms, 0);
    chk("midrst_ovf", OutOverflow, 0);
    #1 RST = 1'b0;
    model_reset();
    #1 chk("midrst_in_ready", InReady, 1);
    @(posedge CLK); #1;
    beat(1, 0, 0, 1);
    check_result("post_rst");
    chk("post_rst_sum_const", OutSum, 1);
    chk("post_rst_terms_const", OutTerms, 1);
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_plane_accumulator.md
# bit_plane_accumulator

Downstream consumer of the value-to-bit converter in the bit-sparsity datapath. Each accepted beat carries one non-zero bit position (BitPlace) of an activation plus the paired signed weight. The block adds `Weight << BitPlace` into a signed accumulator, so a dot product is built from only the set activation bits. At a group boundary it presents the sum, term count and overflow flag through a valid/ready output port.

## Interface
- ACC_WIDTH, 20: accumulator and result width, signed two's complement.
- WEIGHT_WIDTH, 8: weight width, signed.
- PLACE_WIDTH, 3: bit-position width. Activations are 2**PLACE_WIDTH bits wide.
- CNT_WIDTH, 8: term-counter width.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- InValid  in  1  input beat present.
- InReady  out  1  block accepts a beat this cycle.
- BitPlace  in  PLACE_WIDTH  set-bit position of the current activation.
- Weight  in  WEIGHT_WIDTH  signed weight paired with this activation.
- InEmpty  in  1  beat carries no bit (zero activation). BitPlace and Weight are ignored.
- GroupLast  in  1  final beat of the dot-product group.
- OutValid  out  1  result held on Out*.
- OutReady  in  1  consumer takes the result.
- OutSum  out  ACC_WIDTH  group sum, modulo 2**ACC_WIDTH.
- OutTerms  out  CNT_WIDTH  number of non-empty beats in the group, saturating.
- OutOverflow  out  1  signed overflow occurred at least once in the group.

## Operation
- Two states: ACC and HOLD.
- **Reset:** state is ACC. acc, terms, ovf, OutValid, OutSum, OutTerms and OutOverflow are all 0. InReady is 1 once RST deasserts.
- **ACC state:**
  - InReady = 1.
  - A beat is accepted when InValid & InReady.
  - Non-empty beat:
    - addend = sign-extend Weight to ACC_WIDTH, then shift left by BitPlace.
    - acc <= acc + addend, wrapping.
    - ovf <= ovf | signed_overflow(acc, addend, result).
    - terms <= terms + 1, saturating at 2**CNT_WIDTH-1.
  - Empty beat: acc, terms and ovf are unchanged.
  - Accepted beat with GroupLast:
    - OutSum, OutTerms and OutOverflow load the post-update values of acc, terms and ovf, so an empty last beat contributes nothing.
    - OutValid <= 1, state <= HOLD.
    - acc, terms and ovf clear to 0 in the same edge.
- **HOLD state:**
  - InReady = 0. InValid beats are left pending, not consumed.
  - Out* stay stable until OutValid & OutReady.
  - On that handshake: OutValid <= 0, state <= ACC. Out* data keep their last value.
- No beat is accepted in the cycle the handshake completes. InReady is purely a function of state.
- **Overflow:** the sum wraps and OutOverflow reports it. There is no saturation of OutSum.

## Timing
- Latency: the result is visible on Out* with OutValid high in the cycle after the GroupLast beat is accepted.
- Throughput: 1 beat per cycle inside a group. Each group boundary costs at least 1 bubble (the HOLD cycle).
- Combinational path: addend shift, ACC_WIDTH add and overflow detect, all within one cycle.
- The input side has no combinational dependence on OutReady.
- Asynchronous RST asserted mid-group or during HOLD:
  - All outputs and state clear immediately, without waiting for a clock edge.
  - The partial group is discarded.
  - The first beat after RST deasserts starts a fresh group from 0.
- A single-beat group is legal: a beat with GroupLast and InEmpty gives OutSum=0, OutTerms=0.

## Structure
- Shared package `bit_sparsity_pkg` holds:
  - the state enum (ACC, HOLD);
  - the default constants PLACE_WIDTH=3, WEIGHT_WIDTH=8, ACC_WIDTH=20, CNT_WIDTH=8.
- The converter uses the same package for PLACE_WIDTH.
- Sub-module `shift_add_unit` is combinational: sign-extend, shift, add, overflow flag. It is parameterised by ACC_WIDTH, WEIGHT_WIDTH and PLACE_WIDTH.
- The top level holds the FSM, the registers and the handshake.

## Test plan
- **Basic group:** Weight=5; beats with BitPlace 0 then 1, GroupLast on the second → OutSum=15, OutTerms=2, OutOverflow=0, OutValid 1 cycle after the second beat.
- **Negative weight:** Weight=-3; BitPlaces 0,1,2,4,5,6,7 (value 0xF7), GroupLast on place 7 → OutSum=0xFFD1B (-741), OutTerms=7.
- **Empty single-beat group:** InEmpty=1 with GroupLast → OutSum=0, OutTerms=0. Then Weight=2, BitPlace=3 with GroupLast → OutSum=16, confirming the accumulator cleared.
- **Backpressure:** OutReady held low 5 cycles with InValid high throughout → OutValid and Out* stable, InReady=0, no beat consumed. OutReady high → OutValid drops next edge, InReady=1 the following cycle, and the pending beat is accepted.
- **Overflow:** Weight=127, BitPlace=7, 33 beats with GroupLast on the last → OutOverflow=1, OutSum=536448-1048576 (-512128), OutTerms=33.
- **Reset mid-group:** 3 beats accepted, then RST pulsed between clock edges → Out* and OutValid=0 immediately, InReady=1 after RST deasserts. Next group (Weight=1, BitPlace=0, GroupLast) → OutSum=1, OutTerms=1.
